// File: rtl/alu_pkg.sv
// alu_pkg: widths and opcode constants shared by operand fetch, ALU and decoder
package alu_pkg;
    localparam int DATA_W = 64;
    localparam int SEL_W  = 3;
    localparam int NREG   = 32;
    localparam int ADDR_W = $clog2(NREG);
    localparam logic [SEL_W-1:0] ALU_NOP = 3'b000;
    localparam logic [SEL_W-1:0] ALU_ADD = 3'b001;
    localparam logic [SEL_W-1:0] ALU_SUB = 3'b010;
    localparam logic [SEL_W-1:0] ALU_MUL = 3'b011;
    localparam logic [SEL_W-1:0] ALU_DIV = 3'b100;
    localparam logic [SEL_W-1:0] ALU_AND = 3'b101;
    localparam logic [SEL_W-1:0] ALU_OR  = 3'b110;
endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x DATA_W registers, two async read ports with write bypass, one sync write port
// ports: clk/rst, rs1/rs2 -> rd1/rd2 (x0 reads 0), wb_en/wb_addr/wb_data write (x0 dropped)
module reg_file
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [NREG];
    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        else if (wb_en && wb_addr != '0)
            regs[wb_addr] <= wb_data;
    end
    // a write landing this cycle is forwarded so the reader never sees the stale value
    always_comb begin
        rd1 = rs1 == '0 ? '0 : (wb_en && wb_addr == rs1) ? wb_data : regs[rs1];
        rd2 = rs2 == '0 ? '0 : (wb_en && wb_addr == rs2) ? wb_data : regs[rs2];
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads ALU operands, muxes immediate into B, registers them behind a valid/ready handshake
// ports: in_valid/in_ready + rs1/rs2/imm/use_imm/sel_in/rd_in issue side; wb_en/wb_addr/wb_data writeback;
//        out_valid/out_ready + a_out/b_out/sel_out/rd_out ALU side
module operand_fetch
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic              use_imm,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [SEL_W-1:0]  sel_out,
    output logic [ADDR_W-1:0] rd_out
);
    logic [DATA_W-1:0] rd1, rd2;
    logic accept;
    reg_file u_rf (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd1(rd1), .rd2(rd2)
    );
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            sel_out   <= ALU_NOP;
            rd_out    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            a_out     <= rd1;
            b_out     <= use_imm ? imm : rd2;
            sel_out   <= sel_in;
            rd_out    <= rd_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and random checks of operand_fetch against a register-array model
module tb_operand_fetch;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, use_imm, wb_en, out_valid, out_ready;
    logic [4:0] rs1, rs2, rd_in, wb_addr, rd_out;
    logic [63:0] imm, wb_data, a_out, b_out;
    logic [2:0] sel_in, sel_out;
    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] mregs [32];
    logic m_valid = 1'b0;
    logic [63:0] m_a = '0, m_b = '0;
    logic [2:0] m_sel = '0;
    logic [4:0] m_rd = '0;

    operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm), .sel_in(sel_in), .rd_in(rd_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .sel_out(sel_out), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] read_reg(input logic [4:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    task automatic idle();
        rst = 0; in_valid = 0; use_imm = 0; wb_en = 0; out_ready = 1;
        rs1 = 0; rs2 = 0; rd_in = 0; wb_addr = 0; imm = 0; wb_data = 0; sel_in = 0;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] s, input logic [4:0] rd);
        in_valid = 1; rs1 = r1; rs2 = r2; sel_in = s; rd_in = rd;
    endtask

    task automatic cycle();
        logic [63:0] na, nb;
        logic acc;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        acc = in_valid && (!m_valid || out_ready);
        na = read_reg(rs1);
        nb = use_imm ? imm : read_reg(rs2);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            m_valid = 0; m_a = '0; m_b = '0; m_sel = '0; m_rd = '0;
        end else begin
            if (acc) begin
                m_valid = 1; m_a = na; m_b = nb; m_sel = sel_in; m_rd = rd_in;
            end else if (out_ready) m_valid = 0;
            if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid || rst) begin
            check("a_out", a_out, m_a);
            check("b_out", b_out, m_b);
            check("sel_out", 64'(sel_out), 64'(m_sel));
            check("rd_out", 64'(rd_out), 64'(m_rd));
        end
    endtask

    initial begin
        logic [63:0] held_a;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        idle();
        rst = 1;
        cycle();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sel", 64'(sel_out), 64'd0);
        idle();
        // 1: x0/x5 after reset both read zero
        issue(5'd0, 5'd5, ALU_ADD, 5'd1);
        cycle();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_a", a_out, 64'd0);
        check("t1_b", b_out, 64'd0);
        check("t1_sel", 64'(sel_out), 64'd1);
        // 2: same-cycle bypass, then writes to x0 are dropped
        issue(5'd7, 5'd0, ALU_SUB, 5'd2);
        wb_en = 1; wb_addr = 5'd7; wb_data = 64'hDEAD_BEEF;
        cycle();
        check("t2_bypass", a_out, 64'hDEAD_BEEF);
        issue(5'd0, 5'd0, ALU_AND, 5'd3);
        wb_addr = 5'd0; wb_data = 64'd5;
        cycle();
        wb_en = 0;
        cycle();
        check("t2_x0", a_out, 64'd0);
        // 3: immediate replaces rs2
        idle();
        wb_en = 1; wb_addr = 5'd3; wb_data = 64'd9;
        cycle();
        idle();
        issue(5'd7, 5'd3, ALU_OR, 5'd4);
        use_imm = 1; imm = 64'hFFFF_FFFF_FFFF_FFF0;
        cycle();
        check("t3_imm", b_out, 64'hFFFF_FFFF_FFFF_FFF0);
        // 4: stall holds outputs even across a write to the held rs1
        use_imm = 0;
        held_a = m_a;
        out_ready = 0;
        issue(5'd7, 5'd3, ALU_MUL, 5'd5);
        for (int i = 0; i < 3; i++) begin
            wb_en = (i == 1); wb_addr = 5'd7; wb_data = 64'h1234;
            cycle();
            check("t4_stall_ready", 64'(in_ready), 64'd0);
            check("t4_hold_a", a_out, held_a);
            check("t4_hold_sel", 64'(sel_out), 64'(ALU_OR));
        end
        wb_en = 0;
        out_ready = 1;
        cycle();
        check("t4_next_a", a_out, 64'h1234);
        check("t4_next_sel", 64'(sel_out), 64'(ALU_MUL));
        // 5: four ops streamed back to back
        for (int i = 0; i < 4; i++) begin
            issue(5'(i), 5'(i + 1), 3'(i), 5'(10 + i));
            cycle();
            check("t5_valid", 64'(out_valid), 64'd1);
            check("t5_rd", 64'(rd_out), 64'(10 + i));
        end
        // 6: reset beats a pending op and a same-cycle write
        idle();
        rst = 1; wb_en = 1; wb_addr = 5'd4; wb_data = 64'h55;
        in_valid = 1; rs1 = 5'd4;
        cycle();
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_sel", 64'(sel_out), 64'd0);
        idle();
        issue(5'd4, 5'd4, ALU_DIV, 5'd6);
        cycle();
        check("t6_x4", a_out, 64'd0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            rd_in = 5'($urandom); sel_in = 3'($urandom);
            use_imm = $urandom_range(0, 1) == 1;
            imm = {$urandom, $urandom};
            wb_en = $urandom_range(0, 1) == 1;
            wb_addr = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
            wb_data = {$urandom, $urandom};
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
